// File: rtl/mux_pkg.sv
// Shared definitions for the word multiplexers: select codes and default datapath width.
// Select codes are reverse-ordered: code 0 picks h, code 7 picks a.
package mux_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] SEL_H = 3'd0;
  localparam logic [2:0] SEL_G = 3'd1;
  localparam logic [2:0] SEL_F = 3'd2;
  localparam logic [2:0] SEL_E = 3'd3;
  localparam logic [2:0] SEL_D = 3'd4;
  localparam logic [2:0] SEL_C = 3'd5;
  localparam logic [2:0] SEL_B = 3'd6;
  localparam logic [2:0] SEL_A = 3'd7;

endpackage

// File: rtl/mux4_to_1_comb.sv
// Combinational WIDTH-bit 4:1 multiplexer; in_k is chosen when sel == k.
// An unknown select drives all-X in simulation and is a don't-care in synthesis.
module mux4_to_1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = {WIDTH{1'bx}};
    case (sel)
      2'd0:    y = in0;
      2'd1:    y = in1;
      2'd2:    y = in2;
      2'd3:    y = in3;
      default: y = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux8_to_1.sv
// Registered 8:1 word multiplexer built from two 4:1 halves; s2 picks the half.
// Optional even-parity output z_par when MUX8_TO_1_PARITY_EN is defined.
module mux8_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] z,
`ifdef MUX8_TO_1_PARITY_EN
  output logic             z_par,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0
);

  // No valid/ready handshake: the block accepts inputs every cycle and z is
  // valid from the first edge after reset is released.

  logic [WIDTH-1:0] low_pick;
  logic [WIDTH-1:0] high_pick;
  logic [WIDTH-1:0] pick;

  // Low half covers codes SEL_H..SEL_E, high half SEL_D..SEL_A.
  mux4_to_1_comb #(.WIDTH(WIDTH)) u_low (
    .in0 (h),
    .in1 (g),
    .in2 (f),
    .in3 (e),
    .sel ({s1, s0}),
    .y   (low_pick)
  );

  mux4_to_1_comb #(.WIDTH(WIDTH)) u_high (
    .in0 (d),
    .in1 (c),
    .in2 (b),
    .in3 (a),
    .sel ({s1, s0}),
    .y   (high_pick)
  );

  // case rather than ?: so an X on s2 yields all-X instead of a bitwise merge.
  always_comb begin
    pick = {WIDTH{1'bx}};
    case (s2)
      1'b0:    pick = low_pick;
      1'b1:    pick = high_pick;
      default: pick = {WIDTH{1'bx}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
    end else begin
      z <= pick;
    end
  end

`ifdef MUX8_TO_1_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      z_par <= 1'b0;
    end else begin
      z_par <= ^pick;
    end
  end
`endif

endmodule

// File: tb/tb_mux8_to_1.sv
// Self-checking bench for mux8_to_1: directed cases plus randomized traffic
// against an array-indexed reference. Define MUX8_TO_1_PARITY_EN to also check z_par.
module tb_mux8_to_1;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic         s2, s1, s0;
  logic [W-1:0] z;
`ifdef MUX8_TO_1_PARITY_EN
  logic         z_par;
`endif

  // ops[k] is the operand that select code k must deliver.
  logic [W-1:0] ops [8];
  assign h = ops[0];
  assign g = ops[1];
  assign f = ops[2];
  assign e = ops[3];
  assign d = ops[4];
  assign c = ops[5];
  assign b = ops[6];
  assign a = ops[7];

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  mux8_to_1 dut (
    .clk   (clk),
    .rst   (rst),
    .z     (z),
`ifdef MUX8_TO_1_PARITY_EN
    .z_par (z_par),
`endif
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .h     (h),
    .s2    (s2),
    .s1    (s1),
    .s0    (s0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] sel, input logic r);
    if (r) return '0;
    return ops[sel];
  endfunction

  // Sets select, records the model's answer, clocks once and compares #1 later.
  task automatic cycle(input string tag, input logic [2:0] sel);
    logic [W-1:0] exp;
    {s2, s1, s0} = sel;
    exp_q.push_back(model(sel, rst));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, z, exp);
`ifdef MUX8_TO_1_PARITY_EN
    check({tag, "_par"}, {31'b0, z_par}, {31'b0, ($countones(exp) % 2) == 1});
`endif
  endtask

  task automatic fill(input logic [W-1:0] sel_val, input logic [W-1:0] rest_val, input logic [2:0] k);
    for (int i = 0; i < 8; i++) ops[i] = (i == int'(k)) ? sel_val : rest_val;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    {s2, s1, s0} = 3'b000;
    for (int i = 0; i < 8; i++) ops[i] = $urandom;

    // reset held for two edges with arbitrary inputs
    cycle("reset0", 3'($urandom_range(0, 7)));
    cycle("reset1", 3'($urandom_range(0, 7)));
    rst = 1'b0;

    // sel 000 one-hot and inverse
    fill(32'hFFFF_FFFF, 32'h0, 3'd0);
    cycle("h_onehot", 3'd0);
    fill(32'h0, 32'hFFFF_FFFF, 3'd0);
    cycle("h_inverse", 3'd0);

    // sweep all codes, one-hot then inverse
    for (int k = 0; k < 8; k++) begin
      fill(32'hFFFF_FFFF, 32'h0, 3'(k));
      cycle($sformatf("sweep_hot%0d", k), 3'(k));
    end
    for (int k = 0; k < 8; k++) begin
      fill(32'h0, 32'hFFFF_FFFF, 3'(k));
      cycle($sformatf("sweep_inv%0d", k), 3'(k));
    end

    // latency: z holds until the next edge, mid-cycle changes are ignored
    for (int i = 0; i < 8; i++) ops[i] = 32'h0;
    ops[7] = 32'hA5A5_A5A5;
    ops[0] = 32'h5A5A_5A5A;
    cycle("lat_a", 3'd7);
    {s2, s1, s0} = 3'b000;
    #2;
    check("lat_hold_sel", z, 32'hA5A5_A5A5);
    ops[7] = 32'h1234_5678;
    #1;
    check("lat_hold_data", z, 32'hA5A5_A5A5);
    cycle("lat_h", 3'd0);

    // reset mid-stream
    fill(32'hFFFF_FFFF, 32'h0, 3'd3);
    cycle("mid_pre", 3'd3);
    rst = 1'b1;
    cycle("mid_rst", 3'd3);
    rst = 1'b0;
    cycle("mid_post", 3'd3);

    // parity boundary words
    fill(32'h0000_0001, 32'h0, 3'd5);
    cycle("par_one", 3'd5);
    fill(32'h0000_0003, 32'h0, 3'd2);
    cycle("par_three", 3'd2);

    // randomized traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) ops[i] = $urandom;
      rst = ($urandom_range(0, 15) == 0);
      cycle("rand", 3'($urandom_range(0, 7)));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
